// File: rtl/sata_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sata_phy_pkg
//  Description : Shared constants, TX state encoding, shift type and the
//                byte-realignment helper for the multi-channel SATA PHY IF.
//  Revision    : 1.0 - initial release
// ============================================================================
package sata_phy_pkg;

    localparam logic [31:0] ALIGN_DW     = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_DW      = 32'hB5B5957C;
    localparam logic [7:0]  K28_5        = 8'hBC;
    localparam logic [3:0]  PRIM_CHARISK = 4'b0001;

    typedef enum logic [1:0] {
        LINK_DN = 2'd0,
        INS0    = 2'd1,
        INS1    = 2'd2,
        DATA    = 2'd3
    } tx_state_t;

    typedef logic [1:0] shift_t;

    // Build a dword starting at byte s of the {cur, prev} byte stream.
    function automatic logic [31:0] realign_dw(input logic [31:0] cur,
                                               input logic [31:0] prev,
                                               input shift_t      s);
        logic [31:0] w_dw;
        w_dw = prev;
        case (s)
            2'd0: w_dw = prev;
            2'd1: w_dw = {cur[7:0],  prev[31:8]};
            2'd2: w_dw = {cur[15:0], prev[31:16]};
            2'd3: w_dw = {cur[23:0], prev[31:24]};
            default: w_dw = prev;
        endcase
        return w_dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sata_phy_if_lane.sv
`default_nettype none
// ============================================================================
//  Module      : sata_phy_if_lane
//  Description : One SATA PHY/link channel: TX ALIGN-insertion FSM with
//                ready/valid, RX comma-based byte realignment with ALIGN
//                stripping, and an optional realignment event counter
//                (enabled by SATA_PHY_IF_STATS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module sata_phy_if_lane
    import sata_phy_pkg::*;
#(
    parameter int C_ALIGN_PERIOD = 256
) (
    input  logic        phyclk,
    input  logic        phyreset,
    input  logic        link_up,
    input  logic [31:0] tx_data,
    input  logic        tx_k,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] txdata_fis,
    output logic [3:0]  tx_charisk_fis,
    input  logic [31:0] rxdata_fis,
    input  logic [3:0]  rxcharisk,
    output logic [31:0] rx_data,
    output logic        rx_k,
    output logic        rx_valid,
    output logic [15:0] realign_cnt
);

    localparam int              CNT_W    = $clog2(C_ALIGN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_ALIGN_PERIOD - 3);

    // ------------------------------------------------------------------ TX
    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [31:0]       r_txdata;
    logic [31:0]       w_txdata_nxt;
    logic [3:0]        r_txk;
    logic [3:0]        w_txk_nxt;
    logic              r_tx_ready;

    // TX state register.
    always_ff @(posedge phyclk) begin
        if (phyreset) r_state <= LINK_DN;
        else          r_state <= w_state_nxt;
    end

    // Next state, window counter and the dword to launch on the next edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_txdata_nxt = ALIGN_DW;
        w_txk_nxt    = PRIM_CHARISK;
        case (r_state)
            LINK_DN: begin
                w_cnt_nxt = '0;
                if (link_up) w_state_nxt = INS0;
            end
            INS0: w_state_nxt = INS1;
            INS1: begin
                w_cnt_nxt   = '0;
                w_state_nxt = DATA;
            end
            DATA: begin
                if (tx_valid) begin
                    w_txdata_nxt = tx_data;
                    w_txk_nxt    = {3'b000, tx_k};
                end else begin
                    w_txdata_nxt = SYNC_DW;
                    w_txk_nxt    = PRIM_CHARISK;
                end
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) w_state_nxt = INS0;
            end
            default: w_state_nxt = LINK_DN;
        endcase
        // Losing the link aborts any window, even mid ALIGN pair.
        if (!link_up) begin
            w_state_nxt = LINK_DN;
            w_cnt_nxt   = '0;
        end
    end

    // Registered TX outputs; ready follows the state being entered.
    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            r_cnt      <= '0;
            r_txdata   <= ALIGN_DW;
            r_txk      <= PRIM_CHARISK;
            r_tx_ready <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_txdata   <= w_txdata_nxt;
            r_txk      <= w_txk_nxt;
            r_tx_ready <= (w_state_nxt == DATA);
        end
    end

    assign tx_ready       = r_tx_ready;
    assign txdata_fis     = r_txdata;
    assign tx_charisk_fis = r_txk;

    // ------------------------------------------------------------------ RX
    logic [31:0] r_prev;
    logic [3:0]  r_prevk;
    shift_t      r_shift;
    logic        w_comma_hit;
    shift_t      w_comma_lane;
    logic [31:0] w_rx_word;
    logic        w_rx_k;
    logic        w_is_align;
    logic [31:0] r_rx_data;
    logic        r_rx_k;
    logic        r_rx_valid;

    // Find the lowest byte lane carrying a K28.5 comma.
    always_comb begin
        w_comma_hit  = 1'b0;
        w_comma_lane = '0;
        for (int b = 3; b >= 0; b--) begin
            if (rxcharisk[b] && (rxdata_fis[8*b +: 8] == K28_5)) begin
                w_comma_hit  = 1'b1;
                w_comma_lane = shift_t'(b);
            end
        end
    end

    assign w_rx_word  = realign_dw(rxdata_fis, r_prev, r_shift);
    assign w_rx_k     = r_prevk[r_shift];
    assign w_is_align = w_rx_k && (w_rx_word == ALIGN_DW);

    // Previous-word stage, shift tracking and the realigned output register.
    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            r_prev     <= '0;
            r_prevk    <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_k     <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_prev  <= rxdata_fis;
            r_prevk <= rxcharisk;
            if (!link_up) begin
                r_shift    <= '0;
                r_rx_valid <= 1'b0;
            end else begin
                if (w_comma_hit) r_shift <= w_comma_lane;
                r_rx_data  <= w_rx_word;
                r_rx_k     <= w_rx_k;
                r_rx_valid <= !w_is_align;
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_k     = r_rx_k;
    assign rx_valid = r_rx_valid;

    // --------------------------------------------------------------- stats
`ifdef SATA_PHY_IF_STATS_EN
    logic [15:0] r_realign_cnt;

    // Count comma-driven shift changes while the link is up, saturating.
    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            r_realign_cnt <= '0;
        end else if (link_up && w_comma_hit && (w_comma_lane != r_shift) &&
                     (r_realign_cnt != 16'hFFFF)) begin
            r_realign_cnt <= r_realign_cnt + 16'd1;
        end
    end

    assign realign_cnt = r_realign_cnt;
`else
    assign realign_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: rtl/sata_phy_if_mc.sv
`default_nettype none
// ============================================================================
//  Module      : sata_phy_if_mc
//  Description : Multi-channel SATA PHY/link interface. Replicates one
//                independent lane per channel on the shared PHY clock.
//                Optional realignment statistics: SATA_PHY_IF_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sata_phy_if_mc
    import sata_phy_pkg::*;
#(
    parameter int C_NUM_CH       = 2,
    parameter int C_ALIGN_PERIOD = 256
) (
    input  logic                    phyclk,
    input  logic                    phyreset,
    input  logic [C_NUM_CH-1:0]     link_up,
    input  logic [32*C_NUM_CH-1:0]  tx_data,
    input  logic [C_NUM_CH-1:0]     tx_k,
    input  logic [C_NUM_CH-1:0]     tx_valid,
    output logic [C_NUM_CH-1:0]     tx_ready,
    output logic [32*C_NUM_CH-1:0]  txdata_fis,
    output logic [4*C_NUM_CH-1:0]   tx_charisk_fis,
    input  logic [32*C_NUM_CH-1:0]  rxdata_fis,
    input  logic [4*C_NUM_CH-1:0]   rxcharisk,
    output logic [32*C_NUM_CH-1:0]  rx_data,
    output logic [C_NUM_CH-1:0]     rx_k,
    output logic [C_NUM_CH-1:0]     rx_valid,
    output logic [16*C_NUM_CH-1:0]  realign_cnt
);

    // One fully independent lane per channel; channel 0 sits in the LSBs.
    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_lane
        sata_phy_if_lane #(
            .C_ALIGN_PERIOD (C_ALIGN_PERIOD)
        ) u_lane (
            .phyclk         (phyclk),
            .phyreset       (phyreset),
            .link_up        (link_up[g]),
            .tx_data        (tx_data[32*g +: 32]),
            .tx_k           (tx_k[g]),
            .tx_valid       (tx_valid[g]),
            .tx_ready       (tx_ready[g]),
            .txdata_fis     (txdata_fis[32*g +: 32]),
            .tx_charisk_fis (tx_charisk_fis[4*g +: 4]),
            .rxdata_fis     (rxdata_fis[32*g +: 32]),
            .rxcharisk      (rxcharisk[4*g +: 4]),
            .rx_data        (rx_data[32*g +: 32]),
            .rx_k           (rx_k[g]),
            .rx_valid       (rx_valid[g]),
            .realign_cnt    (realign_cnt[16*g +: 16])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sata_phy_if_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sata_phy_if_mc
//  Description : Scoreboard bench for sata_phy_if_mc (4 channels, 8-dword
//                ALIGN window). Realignment counter expectations follow
//                SATA_PHY_IF_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sata_phy_if_mc;

    localparam int N = 4;
    localparam int P = 8;
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;

    logic              phyclk = 1'b0;
    logic              phyreset;
    logic [N-1:0]      link_up;
    logic [32*N-1:0]   tx_data;
    logic [N-1:0]      tx_k;
    logic [N-1:0]      tx_valid;
    logic [N-1:0]      tx_ready;
    logic [32*N-1:0]   txdata_fis;
    logic [4*N-1:0]    tx_charisk_fis;
    logic [32*N-1:0]   rxdata_fis;
    logic [4*N-1:0]    rxcharisk;
    logic [32*N-1:0]   rx_data;
    logic [N-1:0]      rx_k;
    logic [N-1:0]      rx_valid;
    logic [16*N-1:0]   realign_cnt;

    sata_phy_if_mc #(.C_NUM_CH(N), .C_ALIGN_PERIOD(P)) dut (
        .phyclk         (phyclk),
        .phyreset       (phyreset),
        .link_up        (link_up),
        .tx_data        (tx_data),
        .tx_k           (tx_k),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .txdata_fis     (txdata_fis),
        .tx_charisk_fis (tx_charisk_fis),
        .rxdata_fis     (rxdata_fis),
        .rxcharisk      (rxcharisk),
        .rx_data        (rx_data),
        .rx_k           (rx_k),
        .rx_valid       (rx_valid),
        .realign_cnt    (realign_cnt)
    );

    always #5 phyclk = ~phyclk;

    // Expected per-cycle view of one channel after an edge.
    typedef struct packed {
        logic [31:0] txd;
        logic [3:0]  txk;
        logic        rdy;
        logic        rxv;
        logic [15:0] rc;
    } cyc_t;
    typedef cyc_t [N-1:0] cycv_t;

    cycv_t       cycq[$];
    logic [32:0] rxq [N][$];
    logic [8:0]  bq  [N][$];

    // Reference model: window position, byte-stream history, stats.
    bit          m_up    [N];
    int          m_pos   [N];
    logic [31:0] m_prev  [N];
    logic [3:0]  m_prevk [N];
    int          m_shift [N];
    int          m_cnt   [N];

    int n_tests;
    int n_fail;

    function automatic void chk(input string nm, input int ch,
                                input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0h expected %0h at %0t", nm, ch, act, exp, $time);
        end
    endfunction

    // Evaluate the model for the coming edge, queue expectations, advance.
    task automatic step();
        cycv_t ev;
        for (int ch = 0; ch < N; ch++) begin
            cyc_t        e;
            logic [31:0] cur;
            logic [3:0]  curk;
            logic [63:0] pair;
            logic [31:0] w;
            logic        k;
            int          lane;
            cur  = rxdata_fis[ch*32 +: 32];
            curk = rxcharisk[ch*4 +: 4];
            if (phyreset) begin
                m_up[ch] = 0; m_pos[ch] = 0; m_prev[ch] = '0; m_prevk[ch] = '0;
                m_shift[ch] = 0; m_cnt[ch] = 0;
                e = '{txd: ALIGN, txk: 4'b0001, rdy: 1'b0, rxv: 1'b0, rc: 16'h0};
            end else begin
                // Window: slots 0,1 are the ALIGN pair, slots 2..P-1 carry data.
                if (m_up[ch] && m_pos[ch] >= 2) begin
                    if (tx_valid[ch]) begin
                        e.txd = tx_data[ch*32 +: 32];
                        e.txk = {3'b000, tx_k[ch]};
                    end else begin
                        e.txd = SYNC;
                        e.txk = 4'b0001;
                    end
                end else begin
                    e.txd = ALIGN;
                    e.txk = 4'b0001;
                end
                if (!link_up[ch])  m_up[ch] = 0;
                else if (!m_up[ch]) begin m_up[ch] = 1; m_pos[ch] = 0; end
                else                m_pos[ch] = (m_pos[ch] + 1) % P;
                e.rdy = m_up[ch] && (m_pos[ch] >= 2);
                // RX: dword taken from the byte stream at offset m_shift.
                pair  = {cur, m_prev[ch]};
                w     = pair[8*m_shift[ch] +: 32];
                k     = m_prevk[ch][m_shift[ch]];
                e.rxv = link_up[ch] && !(k && w == ALIGN);
                if (e.rxv) rxq[ch].push_back({k, w});
                lane = -1;
                for (int b = 0; b < 4; b++)
                    if (lane < 0 && curk[b] && cur[8*b +: 8] == 8'hBC) lane = b;
                if (link_up[ch]) begin
                    if (lane >= 0) begin
                        if (lane != m_shift[ch] && m_cnt[ch] < 65535) m_cnt[ch]++;
                        m_shift[ch] = lane;
                    end
                end else begin
                    m_shift[ch] = 0;
                end
                m_prev[ch]  = cur;
                m_prevk[ch] = curk;
`ifdef SATA_PHY_IF_STATS_EN
                e.rc = 16'(m_cnt[ch]);
`else
                e.rc = 16'h0;
`endif
            end
            ev[ch] = e;
        end
        cycq.push_back(ev);
        @(negedge phyclk);
    endtask

    // Random RX byte stream: data, SYNC, ALIGN and occasional slip bytes.
    task automatic refill(input int ch);
        int r;
        logic [31:0] d;
        while (bq[ch].size() < 8) begin
            r = $urandom_range(0, 15);
            if (r < 2) begin
                bq[ch].push_back(9'h1BC); bq[ch].push_back(9'h04A);
                bq[ch].push_back(9'h04A); bq[ch].push_back(9'h07B);
            end else if (r == 2) begin
                repeat ($urandom_range(1, 3)) bq[ch].push_back({1'b0, 8'($urandom)});
            end else if (r == 3) begin
                bq[ch].push_back(9'h17C); bq[ch].push_back(9'h095);
                bq[ch].push_back(9'h0B5); bq[ch].push_back(9'h0B5);
            end else begin
                d = $urandom;
                for (int b = 0; b < 4; b++) bq[ch].push_back({1'b0, d[8*b +: 8]});
            end
        end
    endtask

    task automatic drive_cycle(input bit fixed_tx);
        logic [8:0] by;
        for (int ch = 0; ch < N; ch++) begin
            tx_data[ch*32 +: 32] = $urandom;
            tx_k[ch] = ($urandom_range(0, 3) == 0);
            if (fixed_tx && ch == 0)      tx_valid[ch] = 1'b1;
            else if (fixed_tx && ch == 1) tx_valid[ch] = 1'b0;
            else                          tx_valid[ch] = ($urandom_range(0, 3) != 0);
            refill(ch);
            for (int b = 0; b < 4; b++) begin
                by = bq[ch].pop_front();
                rxdata_fis[ch*32 + 8*b +: 8] = by[7:0];
                rxcharisk[ch*4 + b]          = by[8];
            end
        end
    endtask

    task automatic set_rx(input int ch, input logic [31:0] d, input logic [3:0] k);
        rxdata_fis[ch*32 +: 32] = d;
        rxcharisk[ch*4 +: 4]    = k;
    endtask

    task automatic check_reset();
        for (int ch = 0; ch < N; ch++) begin
            chk("rst_txdata",   ch, 64'(txdata_fis[ch*32 +: 32]),  64'(ALIGN));
            chk("rst_charisk",  ch, 64'(tx_charisk_fis[ch*4 +: 4]), 64'h1);
            chk("rst_tx_ready", ch, 64'(tx_ready[ch]),  64'h0);
            chk("rst_rx_data",  ch, 64'(rx_data[ch*32 +: 32]), 64'h0);
            chk("rst_rx_k",     ch, 64'(rx_k[ch]),      64'h0);
            chk("rst_rx_valid", ch, 64'(rx_valid[ch]),  64'h0);
            chk("rst_realign",  ch, 64'(realign_cnt[ch*16 +: 16]), 64'h0);
        end
    endtask

    // Monitor: compare every cycle; pop RX words whenever the DUT presents one.
    initial begin
        cycv_t ev;
        logic [32:0] x;
        forever begin
            @(posedge phyclk);
            #1;
            if (cycq.size() != 0) begin
                ev = cycq.pop_front();
                for (int ch = 0; ch < N; ch++) begin
                    chk("txdata_fis", ch, 64'(txdata_fis[ch*32 +: 32]), 64'(ev[ch].txd));
                    chk("tx_charisk", ch, 64'(tx_charisk_fis[ch*4 +: 4]), 64'(ev[ch].txk));
                    chk("tx_ready",   ch, 64'(tx_ready[ch]), 64'(ev[ch].rdy));
                    chk("rx_valid",   ch, 64'(rx_valid[ch]), 64'(ev[ch].rxv));
                    chk("realign_cnt", ch, 64'(realign_cnt[ch*16 +: 16]), 64'(ev[ch].rc));
                    if (rx_valid[ch]) begin
                        if (rxq[ch].size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL rx_unexpected ch%0d: got %0h expected none", ch, rx_data[ch*32 +: 32]);
                        end else begin
                            x = rxq[ch].pop_front();
                            chk("rx_word", ch, 64'({rx_k[ch], rx_data[ch*32 +: 32]}), 64'(x));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int sat_cycles;
        logic [15:0] cnt_before;
        n_tests = 0; n_fail = 0;
        phyreset = 1'b1; link_up = '0; tx_data = '0; tx_k = '0; tx_valid = '0;
        rxdata_fis = '0; rxcharisk = '0;
        @(negedge phyclk);
        repeat (3) step();
        check_reset();
        phyreset = 1'b0;

        // Full windows: ch0 streams data, ch1 idles with SYNC.
        link_up = '1;
        repeat (40) begin drive_cycle(1'b1); step(); end

        // Drop ch2's link while it is sending the first ALIGN of a pair.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive_cycle(1'b0);
            if (m_up[2] && m_pos[2] == 0) found = 1;
            else step();
        end
        chk("find_ins0", 2, 64'(found), 64'h1);
        link_up[2] = 1'b0;
        repeat (3) begin
            drive_cycle(1'b0); step();
            chk("drop_ready", 2, 64'(tx_ready[2]), 64'h0);
            chk("drop_align", 2, 64'(txdata_fis[64 +: 32]), 64'(ALIGN));
        end
        link_up[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive_cycle(1'b0); step();
            chk("relink_ready", 2, 64'(tx_ready[2]), 64'((i >= 3 && i <= 8) ? 1 : 0));
        end

        // Comma in byte 2, then 0x11223344 straddling two raw words.
        drive_cycle(1'b0); set_rx(0, 32'h4ABC_0000, 4'b0100); step();
        drive_cycle(1'b0); set_rx(0, 32'h3344_7B4A, 4'b0000); step();
        chk("align_dropped", 0, 64'(rx_valid[0]), 64'h0);
        drive_cycle(1'b0); set_rx(0, 32'h5566_1122, 4'b0000); step();
        chk("realign_valid", 0, 64'(rx_valid[0]), 64'h1);
        chk("realign_data",  0, 64'(rx_data[31:0]), 64'h1122_3344);
        chk("realign_k",     0, 64'(rx_k[0]), 64'h0);

        // Comma moves from lane 1 to lane 3 on ch1.
        drive_cycle(1'b0); set_rx(1, 32'h0000_BC00, 4'b0010); step();
        cnt_before = realign_cnt[31:16];
        drive_cycle(1'b0); set_rx(1, 32'h1234_5678, 4'b0000); step();
        drive_cycle(1'b0); set_rx(1, 32'hBC00_0000, 4'b1000); step();
`ifdef SATA_PHY_IF_STATS_EN
        chk("shift_change", 1, 64'(realign_cnt[31:16]), 64'(cnt_before + 16'd1));
`else
        chk("stats_off", 1, 64'(realign_cnt[31:16]), 64'h0);
`endif

        // Random traffic; ch3 link toggles, mid-run reset with ch2 active.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) link_up[3] = ~link_up[3];
            if ($urandom_range(0, 200) == 0) link_up[1] = ~link_up[1];
            if (i == 1500) begin
                link_up[2] = 1'b1;
                drive_cycle(1'b0);
                phyreset = 1'b1;
                step();
                check_reset();
                phyreset = 1'b0;
            end
            drive_cycle(1'b0);
            step();
        end

        // Saturate ch1's counter by flipping the comma lane every word.
        link_up = '1;
`ifdef SATA_PHY_IF_STATS_EN
        sat_cycles = 65540;
`else
        sat_cycles = 200;
`endif
        for (int i = 0; i < sat_cycles; i++) begin
            drive_cycle(1'b0);
            if (i % 2 == 0) set_rx(1, 32'h0000_BC00, 4'b0010);
            else            set_rx(1, 32'hBC00_0000, 4'b1000);
            step();
        end
`ifdef SATA_PHY_IF_STATS_EN
        chk("saturate", 1, 64'(realign_cnt[31:16]), 64'hFFFF);
`else
        chk("saturate_off", 1, 64'(realign_cnt[31:16]), 64'h0);
`endif

        // Drain and confirm every predicted RX word was delivered.
        link_up = '0;
        repeat (3) begin drive_cycle(1'b0); step(); end
        @(posedge phyclk);
        #2;
        for (int ch = 0; ch < N; ch++) chk("rxq_drained", ch, 64'(rxq[ch].size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
